branch_resolve_unit: RTL and testbench

Execute-stage branch resolver for the 5-stage RISC-V core. It evaluates conditional branches, JAL and JALR using forwarded operands, and checks the outcome against the prediction carried down the pipe with the instruction. It registers the actual outcome for the branch prediction unit and issues a one-cycle redirect/flush to fetch on a misprediction. After a redirect it squashes wrong-path branches in its own shadow.

---
 rtl/bru_pkg.sv | 27 ++
 rtl/branch_compare.sv | 36 +++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// bru_pkg: shared constants and types for the branch resolve unit.
// Holds funct3 encodings, the resolution bundle and the shadow default.
package bru_pkg;

   localparam int BRU_XLEN       = 32;
   localparam int BRU_SHADOW_DEF = 2;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_R010 = 3'b010;
   localparam logic [2:0] F3_R011 = 3'b011;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic [BRU_XLEN-1:0] pc;
      logic                taken;
      logic [BRU_XLEN-1:0] target;
   } bru_resolve_t;

   function automatic logic f3_reserved(input logic [2:0] f3);
      return (f3 == F3_R010) || (f3 == F3_R011);
   endfunction

endpackage

// File: rtl/branch_compare.sv
// branch_compare: combinational condition evaluator for conditional branches.
// Reserved funct3 encodings report illegal and evaluate as false.
module branch_compare
   import bru_pkg::*;
#(
   parameter int XLEN = BRU_XLEN
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      funct3,
   output logic            cond_true,
   output logic            illegal
);

   logic eq;
   logic lt;
   logic ltu;

   always_comb begin
      eq        = (rs1 == rs2);
      lt        = ($signed(rs1) < $signed(rs2));
      ltu       = (rs1 < rs2);
      cond_true = 1'b0;
      illegal   = f3_reserved(funct3);
      unique case (funct3)
         F3_BEQ:  cond_true = eq;
         F3_BNE:  cond_true = ~eq;
         F3_BLT:  cond_true = lt;
         F3_BGE:  cond_true = ~lt;
         F3_BLTU: cond_true = ltu;
         F3_BGEU: cond_true = ~ltu;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolver with redirect and squash.
// Define BRU_PERF_CNT_EN to add saturating branch/mispredict counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int XLEN          = BRU_XLEN,
   parameter int SHADOW_CYCLES = BRU_SHADOW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            stall,
   input  logic            ex_is_branch,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_rs1_val,
   input  logic [XLEN-1:0] ex_rs2_val,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            branch_resolved,
   output logic [XLEN-1:0] branch_pc,
   output logic            branch_taken_actual,
   output logic [XLEN-1:0] branch_target_actual,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            illegal_branch,
   output logic            misalign_exc
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] perf_branches,
   output logic [XLEN-1:0] perf_mispredicts
`endif
);

   localparam int SW = (SHADOW_CYCLES > 0) ?
                       $clog2(SHADOW_CYCLES + 1) : 1;
   localparam logic [SW-1:0] SQ_LOAD = SW'(SHADOW_CYCLES);

   logic [SW-1:0]   squash_cnt;
   bru_resolve_t    res_d;
   bru_resolve_t    res_q;

   logic            cond_true;
   logic            cmp_illegal;
   logic            is_cf;
   logic            capture;
   logic            br_illegal;
   logic            taken;
   logic            mispred;
   logic            misal;
   logic            redir;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;

   branch_compare #(
      .XLEN      (XLEN)
   ) u_cmp (
      .rs1       (ex_rs1_val),
      .rs2       (ex_rs2_val),
      .funct3    (ex_funct3),
      .cond_true (cond_true),
      .illegal   (cmp_illegal)
   );

   always_comb begin
      is_cf      = ex_is_branch | ex_is_jal | ex_is_jalr;
      capture    = ex_valid & ~stall & is_cf &
                   (squash_cnt == '0);
      br_illegal = ex_is_branch & cmp_illegal;
      sum        = (ex_is_jalr ? ex_rs1_val : ex_pc) + ex_imm;
      target     = {sum[XLEN-1:1], sum[0] & ~ex_is_jalr};
      taken      = ex_is_jal | ex_is_jalr |
                   (ex_is_branch & cond_true & ~cmp_illegal);
      mispred    = (taken != ex_pred_taken) |
                   (taken & ex_pred_taken &
                    (target != ex_pred_target));
      // A misaligned target traps instead of redirecting fetch.
      misal      = taken & target[1];
      redir      = mispred & ~misal;
      next_pc    = taken ? target : (ex_pc + XLEN'(4));
      res_d.pc     = BRU_XLEN'(ex_pc);
      res_d.taken  = taken;
      res_d.target = BRU_XLEN'(target);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_q           <= '0;
         redirect_pc     <= '0;
         branch_resolved <= 1'b0;
         redirect        <= 1'b0;
         illegal_branch  <= 1'b0;
         misalign_exc    <= 1'b0;
      end else begin
         branch_resolved <= capture;
         redirect        <= capture & redir;
         illegal_branch  <= capture & br_illegal;
         misalign_exc    <= capture & misal;
         if (capture) begin
            res_q       <= res_d;
            redirect_pc <= next_pc;
         end
      end
   end

   // Wrong-path shadow: counts only cycles the pipe actually advances.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         squash_cnt <= '0;
      end else if (capture & redir) begin
         squash_cnt <= SQ_LOAD;
      end else if (!stall && squash_cnt != '0) begin
         squash_cnt <= squash_cnt - SW'(1);
      end
   end

   assign branch_pc            = XLEN'(res_q.pc);
   assign branch_taken_actual  = res_q.taken;
   assign branch_target_actual = XLEN'(res_q.target);

`ifdef BRU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (capture && ~&perf_branches)
            perf_branches <= perf_branches + XLEN'(1);
         if (capture && redir && ~&perf_mispredicts)
            perf_mispredicts <= perf_mispredicts + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks of branch_resolve_unit
// against a behavioural resolution model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic        stall = 1'b0;
   logic        ex_is_branch = 1'b0;
   logic        ex_is_jal = 1'b0;
   logic        ex_is_jalr = 1'b0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_pc = '0;
   logic [31:0] ex_rs1_val = '0;
   logic [31:0] ex_rs2_val = '0;
   logic [31:0] ex_imm = '0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_pred_target = '0;

   logic        branch_resolved;
   logic [31:0] branch_pc;
   logic        branch_taken_actual;
   logic [31:0] branch_target_actual;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        illegal_branch;
   logic        misalign_exc;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
`endif

   int n_run  = 0;
   int n_fail = 0;

   // reference model state
   int          m_sq  = 0;
   logic [31:0] m_pc  = '0;
   logic        m_tk  = 1'b0;
   logic [31:0] m_tgt = '0;
   logic [31:0] m_rpc = '0;
   int          m_nbr = 0;
   int          m_nmis = 0;
   logic [100:0] exp_v = '0;
   logic [100:0] obs;

   assign obs = {branch_resolved, redirect, illegal_branch,
                 misalign_exc, branch_taken_actual, branch_pc,
                 branch_target_actual, redirect_pc};

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk                  (clk),
      .rst                  (rst),
      .ex_valid             (ex_valid),
      .stall                (stall),
      .ex_is_branch         (ex_is_branch),
      .ex_is_jal            (ex_is_jal),
      .ex_is_jalr           (ex_is_jalr),
      .ex_funct3            (ex_funct3),
      .ex_pc                (ex_pc),
      .ex_rs1_val           (ex_rs1_val),
      .ex_rs2_val           (ex_rs2_val),
      .ex_imm               (ex_imm),
      .ex_pred_taken        (ex_pred_taken),
      .ex_pred_target       (ex_pred_target),
      .branch_resolved      (branch_resolved),
      .branch_pc            (branch_pc),
      .branch_taken_actual  (branch_taken_actual),
      .branch_target_actual (branch_target_actual),
      .redirect             (redirect),
      .redirect_pc          (redirect_pc),
      .illegal_branch       (illegal_branch),
      .misalign_exc         (misalign_exc)
`ifdef BRU_PERF_CNT_EN
      ,
      .perf_branches        (perf_branches),
      .perf_mispredicts     (perf_mispredicts)
`endif
   );

   task automatic model_reset();
      m_sq = 0; m_pc = '0; m_tk = 1'b0; m_tgt = '0; m_rpc = '0;
      m_nbr = 0; m_nmis = 0;
   endtask

   // Predicts what the DUT shows after the coming clock edge.
   task automatic model_edge();
      bit cond, ill, tk, mis, mal, cap, rd;
      logic [31:0] tgt;
      cond = 0; ill = 0;
      case (ex_funct3)
         3'd0: cond = (ex_rs1_val == ex_rs2_val);
         3'd1: cond = (ex_rs1_val != ex_rs2_val);
         3'd4: cond = ($signed(ex_rs1_val) < $signed(ex_rs2_val));
         3'd5: cond = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
         3'd6: cond = (ex_rs1_val < ex_rs2_val);
         3'd7: cond = (ex_rs1_val >= ex_rs2_val);
         default: ill = 1;
      endcase
      if (ex_is_jalr) tgt = (ex_rs1_val + ex_imm) & 32'hFFFF_FFFE;
      else tgt = ex_pc + ex_imm;
      tk  = ex_is_jal || ex_is_jalr || (ex_is_branch && cond);
      mis = (tk != ex_pred_taken) ||
            (tk && ex_pred_taken && tgt != ex_pred_target);
      mal = tk && tgt[1];
      rd  = mis && !mal;
      cap = ex_valid && !stall && m_sq == 0 &&
            (ex_is_branch || ex_is_jal || ex_is_jalr);
      if (cap) begin
         m_pc = ex_pc; m_tk = tk; m_tgt = tgt;
         m_rpc = tk ? tgt : ex_pc + 32'd4;
         m_nbr++;
         if (rd) m_nmis++;
      end
      exp_v = {cap, cap && rd, cap && ex_is_branch && ill,
               cap && mal, m_tk, m_pc, m_tgt, m_rpc};
      if (cap && rd) m_sq = 2;
      else if (!stall && m_sq > 0) m_sq--;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // cls: 0 none, 1 branch, 2 jal, 3 jalr
   task automatic drive(input bit v, input bit s, input int cls,
                        input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit pt,
                        input logic [31:0] ptgt);
      ex_valid = v; stall = s;
      ex_is_branch = (cls == 1); ex_is_jal = (cls == 2);
      ex_is_jalr = (cls == 3);
      ex_funct3 = f3; ex_pc = pc; ex_rs1_val = a; ex_rs2_val = b;
      ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_run++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_state got %h want 0", obs);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

`ifdef BRU_PERF_CNT_EN
   task automatic test_perf();
      drive(1, 0, 1, 3'd0, 32'h40, 5, 5, 32'h10, 1, 32'h50);
      tick();
      drive(1, 0, 1, 3'd1, 32'h44, 5, 5, 32'h10, 0, 0);
      tick();
      drive(1, 0, 1, 3'd0, 32'h48, 5, 5, 32'h10, 0, 0);
      tick();
      n_run++;
      if ({perf_branches, perf_mispredicts} !== {32'd3, 32'd1}) begin
         n_fail++;
         $display("FAIL perf got br=%0d mis=%0d want 3/1",
                  perf_branches, perf_mispredicts);
      end
      idle(3);
   endtask
`endif

   task automatic test_beq();
      drive(1, 0, 1, 3'd0, 32'h100, 5, 5, 32'h20, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, branch_taken_actual, branch_target_actual,
           redirect, redirect_pc} !==
          {1'b1, 1'b1, 32'h120, 1'b1, 32'h120}) begin
         n_fail++;
         $display("FAIL beq got res=%b tk=%b tgt=%h rd=%b rpc=%h",
                  branch_resolved, branch_taken_actual,
                  branch_target_actual, redirect, redirect_pc);
      end
      idle(3);
      n_run++;
      if ({branch_resolved, redirect} !== 2'b00) begin
         n_fail++;
         $display("FAIL beq_pulse got res=%b rd=%b want 0/0",
                  branch_resolved, redirect);
      end
   endtask

   task automatic test_signed_unsigned();
      drive(1, 0, 1, 3'd4, 32'h200, 32'hFFFF_FFFF, 1, 32'h40,
            1, 32'h240);
      tick();
      n_run++;
      if ({branch_resolved, branch_taken_actual, redirect} !== 3'b110)
      begin
         n_fail++;
         $display("FAIL blt got res=%b tk=%b rd=%b want 1/1/0",
                  branch_resolved, branch_taken_actual, redirect);
      end
      drive(1, 0, 1, 3'd6, 32'h204, 32'hFFFF_FFFF, 1, 32'h40, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, branch_taken_actual, redirect,
           redirect_pc} !== {3'b100, 32'h208}) begin
         n_fail++;
         $display("FAIL bltu got res=%b tk=%b rd=%b rpc=%h",
                  branch_resolved, branch_taken_actual, redirect,
                  redirect_pc);
      end
   endtask

   task automatic test_jalr_misalign();
      drive(1, 0, 3, 3'd0, 32'h300, 32'h203, 0, 0, 1, 32'h200);
      tick();
      n_run++;
      if ({branch_resolved, branch_taken_actual, branch_target_actual,
           misalign_exc, redirect} !==
          {1'b1, 1'b1, 32'h202, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL jalr got res=%b tk=%b tgt=%h mal=%b rd=%b",
                  branch_resolved, branch_taken_actual,
                  branch_target_actual, misalign_exc, redirect);
      end
      drive(1, 0, 1, 3'd1, 32'h304, 7, 7, 8, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, misalign_exc} !== 2'b10) begin
         n_fail++;
         $display("FAIL jalr_noshadow got res=%b mal=%b want 1/0",
                  branch_resolved, misalign_exc);
      end
   endtask

   task automatic test_squash();
      drive(1, 0, 1, 3'd0, 32'h400, 9, 9, 8, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, redirect, redirect_pc} !==
          {2'b11, 32'h408}) begin
         n_fail++;
         $display("FAIL squash_redirect got res=%b rd=%b rpc=%h",
                  branch_resolved, redirect, redirect_pc);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, i == 1, 1, 3'd1, 32'h500 + 4 * i, 3, 3, 8, 0, 0);
         tick();
         n_run++;
         if ({branch_resolved, branch_pc} !== {1'b0, 32'h400}) begin
            n_fail++;
            $display("FAIL squash_shadow[%0d] got res=%b pc=%h",
                     i, branch_resolved, branch_pc);
         end
      end
      drive(1, 0, 1, 3'd1, 32'h600, 3, 3, 8, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, branch_pc} !== {1'b1, 32'h600}) begin
         n_fail++;
         $display("FAIL squash_after got res=%b pc=%h want 1/600",
                  branch_resolved, branch_pc);
      end
   endtask

   task automatic test_illegal();
      drive(1, 0, 1, 3'd2, 32'h700, 1, 2, 32'h10, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, illegal_branch, branch_taken_actual,
           redirect} !== 4'b1100) begin
         n_fail++;
         $display("FAIL illegal got res=%b ill=%b tk=%b rd=%b",
                  branch_resolved, illegal_branch,
                  branch_taken_actual, redirect);
      end
      drive(1, 1, 1, 3'd3, 32'h704, 1, 2, 32'h10, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, illegal_branch, branch_pc} !==
          {2'b00, 32'h700}) begin
         n_fail++;
         $display("FAIL stall_hold got res=%b ill=%b pc=%h",
                  branch_resolved, illegal_branch, branch_pc);
      end
      stall = 1'b0;
      tick();
      n_run++;
      if ({branch_resolved, illegal_branch, branch_pc} !==
          {2'b11, 32'h704}) begin
         n_fail++;
         $display("FAIL stall_release got res=%b ill=%b pc=%h",
                  branch_resolved, illegal_branch, branch_pc);
      end
   endtask

   task automatic test_async_reset();
      drive(1, 0, 2, 3'd0, 32'h800, 0, 0, 32'h40, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, redirect} !== 2'b11) begin
         n_fail++;
         $display("FAIL pre_reset got res=%b rd=%b want 1/1",
                  branch_resolved, redirect);
      end
      #2 rst = 1'b0;
      #1;
      n_run++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL async_reset got %h want 0", obs);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      drive(1, 0, 1, 3'd1, 32'h900, 4, 4, 8, 0, 0);
      tick();
      n_run++;
      if ({branch_resolved, branch_pc} !== {1'b1, 32'h900}) begin
         n_fail++;
         $display("FAIL first_capture got res=%b pc=%h want 1/900",
                  branch_resolved, branch_pc);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, pc, imm, ptgt;
      for (int i = 0; i < 400; i++) begin
         a  = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
         b  = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
         pc = $urandom & 32'hFFFF_FFFC;
         imm = $urandom_range(0, 3) == 0 ? $urandom :
               ($urandom & 32'h0000_0FFC);
         ptgt = $urandom_range(0, 1) ? pc + imm : $urandom;
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3), 3'($urandom_range(0, 7)),
               pc, a, b, imm, $urandom_range(0, 1), ptgt);
         tick();
         n_run++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rand[%0d] got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
`ifdef BRU_PERF_CNT_EN
      test_perf();
`endif
      test_beq();
      test_signed_unsigned();
      test_jalr_misalign();
      test_squash();
      idle(3);
      test_illegal();
      test_async_reset();
      idle(3);
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
